uart_tx_fifo: RTL and testbench
===============================

// Module: uart_tx_fifo
// PURPOSE
//  Byte buffer upstream of the UART transmitter. Software/logic pushes bytes at
//  up to one per clk; the block holds them in a circular FIFO and issues them one
//  at a time to the transmitter over its data/send/ready handshake. data is held
//  stable for the whole frame, and an entry is popped only after the frame completes.
// PARAMETERS
//  DEPTH_LOG2   4   FIFO depth = 2**DEPTH_LOG2 entries (16); legal range 1..8
// PORTS
//  clk        in   1             system clock; all logic on posedge
//  rst        in   1             asynchronous reset, active-low (0 = reset)
//  wr_data    in   8             byte to enqueue
//  wr_en      in   1             enqueue strobe, sampled each clk
//  flush      in   1             synchronous clear of all stored entries
//  clr_ovf    in   1             clears sticky overflow flag
//  full       out  1             count == DEPTH
//  empty      out  1             count == 0
//  count      out  DEPTH_LOG2+1  stored entries, including the one in flight
//  overflow   out  1             sticky: a write was dropped
//  tx_data    out  8             byte to transmitter; registered
//  tx_send    out  1             one-cycle start request to transmitter
//  tx_ready   in   1             transmitter idle (high only in its READY state)
// BEHAVIOUR
//  Reset (rst=0, async): rd/wr pointers=0, count=0, empty=1, full=0, overflow=0,
//   tx_send=0, tx_data=8'h00, FSM=IDLE, pop_ok=0.
//  Storage: pointers DEPTH_LOG2 bits, natural wrap at DEPTH-1 -> 0; count is separate.
//  Write: accepted when wr_en & (~full | pop_this_cycle). Mem[wr_ptr] <= wr_data,
//   wr_ptr++. wr_en & full & ~pop -> data dropped, overflow <= 1.
//  Pop (end of frame): rd_ptr++, count--. Simultaneous accepted write + pop -> count unchanged.
//  Overflow: set has priority over clr_ovf in the same cycle.
//  FSM (registered, advances each clk):
//   IDLE      : ~empty & tx_ready & ~flush -> ISSUE; tx_data <= mem[rd_ptr], pop_ok <= 1.
//   ISSUE     : tx_send=1 (exactly this one cycle) -> WAIT_BUSY.
//   WAIT_BUSY : wait tx_ready==0 (transmitter left READY) -> WAIT_DONE.
//   WAIT_DONE : wait tx_ready==1 -> IDLE; pop if pop_ok, pop_ok <= 0.
//   Unused encodings -> IDLE.
//  tx_data changes only on IDLE->ISSUE, so it is stable through the transmitter's
//   START capture and the full frame. Writes never disturb tx_data.
//  Latency: write at edge N into empty FIFO with tx_ready=1 -> count=1 after N,
//   FSM=ISSUE after N+1, tx_send=1 during cycle N+1..N+2. Back-to-back bytes:
//   next tx_send is 2 clks after tx_ready returns high.
//  Flush: pointers=0, count=0, empty=1, pop_ok <= 0, and same-cycle writes are ignored
//   (flush wins). The FSM is not aborted: an in-flight frame completes, the FSM walks
//   back to IDLE, and no pop occurs. overflow is unaffected.
//  Count never underflows. A pop with count==0 is impossible by construction
//   (pop_ok is cleared by flush).
//  Mid-frame reset: all state clears immediately. The transmitter owns its own reset.
// TESTING
//  1 Reset: assert rst=0 mid-traffic -> empty=1, full=0, count=0, tx_send=0, overflow=0.
//  2 Single byte: write 8'hA5, tx_ready=1 -> tx_send high 1 clk one cycle after count=1,
//    tx_data=8'hA5. Model tx_ready low 10 clks then high -> count 1->0, empty=1.
//  3 Burst: write 8'h01..8'h10 (16) with transmitter model busy -> full=1, count=16.
//    17th write 8'h11 -> dropped, overflow=1. Bytes then emerge 01..10 in order;
//    ptr wrap is checked by a second 16-byte burst.
//  4 Full+pop: count=16, write 8'h77 on the same clk as the pop -> accepted, count stays 16,
//    overflow unchanged, 8'h77 is transmitted last.
//  5 Flush mid-frame: 3 queued, first in WAIT_DONE, flush=1 -> count=0. On tx_ready rise,
//    FSM returns to IDLE, no pop, count stays 0, no further tx_send.
//  6 Stability: during WAIT_BUSY/WAIT_DONE, write 8 random bytes -> tx_data constant;
//    clr_ovf with a dropped write on the same clk -> overflow stays 1.

Source files
------------

// File: rtl/uart_tx_fifo.sv
// Circular byte FIFO feeding a UART transmitter over a data/send/ready handshake.
// An entry stays counted until its frame completes, so count includes the byte in flight.
module uart_tx_fifo #(
   parameter int unsigned DEPTH_LOG2 = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [7:0]            wr_data,
   input  logic                  wr_en,
   input  logic                  flush,
   input  logic                  clr_ovf,
   output logic                  full,
   output logic                  empty,
   output logic [DEPTH_LOG2:0]   count,
   output logic                  overflow,
   output logic [7:0]            tx_data,
   output logic                  tx_send,
   input  logic                  tx_ready
);

   localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
   localparam logic [DEPTH_LOG2:0] FULL_CNT = {1'b1, {DEPTH_LOG2{1'b0}}};

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      WAIT_BUSY,
      WAIT_DONE
   } state_t;

   state_t                  state;
   state_t                  state_nx;
   logic [7:0]              mem [DEPTH];
   logic [DEPTH_LOG2-1:0]   wr_ptr;
   logic [DEPTH_LOG2-1:0]   rd_ptr;
   logic                    pop_ok;
   logic                    load;
   logic                    frame_end;
   logic                    pop;
   logic                    wr_accept;
   logic                    wr_drop;

   assign full  = (count == FULL_CNT);
   assign empty = (count == '0);

   // A pop frees a slot in the same cycle, so a write to a full FIFO still lands.
   assign wr_accept = wr_en & ~flush & (~full | pop);
   assign wr_drop   = wr_en & ~flush & full & ~pop;

   always_comb begin
      state_nx  = state;
      tx_send   = 1'b0;
      load      = 1'b0;
      frame_end = 1'b0;
      pop       = 1'b0;
      case (state)
         IDLE: begin
            if (!empty && tx_ready && !flush) begin
               state_nx = ISSUE;
               load     = 1'b1;
            end
         end
         ISSUE: begin
            tx_send  = 1'b1;
            state_nx = WAIT_BUSY;
         end
         WAIT_BUSY: begin
            if (!tx_ready) state_nx = WAIT_DONE;
         end
         WAIT_DONE: begin
            if (tx_ready) begin
               state_nx  = IDLE;
               frame_end = 1'b1;
               pop       = pop_ok & ~flush;
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= IDLE;
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         pop_ok   <= 1'b0;
         overflow <= 1'b0;
         tx_data  <= '0;
      end else begin
         state <= state_nx;
         // Flush drops storage only; a frame already issued runs to completion without a pop.
         if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            pop_ok <= 1'b0;
         end else begin
            if (wr_accept) wr_ptr <= wr_ptr + 1'b1;
            if (pop)       rd_ptr <= rd_ptr + 1'b1;
            case ({wr_accept, pop})
               2'b10:   count <= count + 1'b1;
               2'b01:   count <= count - 1'b1;
               default: ;
            endcase
            if (load)           pop_ok <= 1'b1;
            else if (frame_end) pop_ok <= 1'b0;
         end
         if (load) tx_data <= mem[rd_ptr];
         if (wr_drop)      overflow <= 1'b1;
         else if (clr_ovf) overflow <= 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (wr_accept) mem[wr_ptr] <= wr_data;
   end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: vector table for fill/overflow behaviour, directed frame sequences,
// and a byte scoreboard checked whenever the DUT asserts tx_send.
module tb_uart_tx_fifo;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic [7:0] wr_data = '0;
   logic       wr_en = 1'b0;
   logic       flush = 1'b0;
   logic       clr_ovf = 1'b0;
   logic       full;
   logic       empty;
   logic [4:0] count;
   logic       overflow;
   logic [7:0] tx_data;
   logic       tx_send;
   logic       tx_ready;

   logic       auto_mode = 1'b0;
   logic       man_ready = 1'b0;
   logic       model_ready = 1'b1;
   int         busy_cnt = 0;
   logic       prev_send = 1'b0;

   int         checks = 0;
   int         errors = 0;
   logic [7:0] exp_q [$];

   typedef struct {
      logic       wr;
      logic [7:0] data;
      logic       clr;
      logic       accept;
      logic [4:0] cnt;
      logic       full;
      logic       empty;
      logic       ovf;
   } vec_t;

   vec_t vecs [20];

   assign tx_ready = auto_mode ? model_ready : man_ready;

   uart_tx_fifo #(.DEPTH_LOG2(4)) dut (
      .clk(clk), .rst(rst), .wr_data(wr_data), .wr_en(wr_en), .flush(flush),
      .clr_ovf(clr_ovf), .full(full), .empty(empty), .count(count),
      .overflow(overflow), .tx_data(tx_data), .tx_send(tx_send), .tx_ready(tx_ready)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic push_wr(input logic [7:0] d, input logic accept);
      wr_en   = 1'b1;
      wr_data = d;
      if (accept) exp_q.push_back(d);
      step();
      wr_en = 1'b0;
   endtask

   task automatic drain(input string name);
      int n = 0;
      while (count != 5'd0 && n < 2000) begin
         step();
         n++;
      end
      chk({name, "_drain_in_time"}, 32'(n < 2000), 1);
      chk({name, "_scoreboard_empty"}, 32'(exp_q.size()), 0);
      chk({name, "_empty"}, 32'(empty), 1);
      step();
   endtask

   task automatic wait_send(input string name);
      int n = 0;
      while (!tx_send && n < 40) begin
         step();
         n++;
      end
      chk({name, "_send_seen"}, 32'(tx_send), 1);
   endtask

   // Transmitter model: drops ready on a send, holds it low for 10 clocks.
   always @(negedge clk) begin
      if (tx_send) begin
         chk("send_one_cycle", 32'(prev_send), 0);
         if (exp_q.size() == 0) chk("send_expected", 32'(exp_q.size()), 1);
         else chk("tx_data_order", 32'(tx_data), 32'(exp_q.pop_front()));
         if (auto_mode) begin
            model_ready = 1'b0;
            busy_cnt    = 10;
         end
      end else if (auto_mode && busy_cnt > 0) begin
         busy_cnt--;
         if (busy_cnt == 0) model_ready = 1'b1;
      end
      prev_send = tx_send;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int i = 0; i < 16; i++)
         vecs[i] = '{1'b1, 8'(i + 1), 1'b0, 1'b1, 5'(i + 1), (i == 15), 1'b0, 1'b0};
      vecs[16] = '{1'b1, 8'h11, 1'b0, 1'b0, 5'd16, 1'b1, 1'b0, 1'b1};
      vecs[17] = '{1'b0, 8'h00, 1'b1, 1'b0, 5'd16, 1'b1, 1'b0, 1'b0};
      vecs[18] = '{1'b1, 8'h12, 1'b1, 1'b0, 5'd16, 1'b1, 1'b0, 1'b1};
      vecs[19] = '{1'b0, 8'h00, 1'b1, 1'b0, 5'd16, 1'b1, 1'b0, 1'b0};

      // Reset state
      repeat (2) step();
      chk("rst_empty", 32'(empty), 1);
      chk("rst_full", 32'(full), 0);
      chk("rst_count", 32'(count), 0);
      chk("rst_send", 32'(tx_send), 0);
      chk("rst_ovf", 32'(overflow), 0);
      chk("rst_txdata", 32'(tx_data), 0);
      rst = 1'b1;
      step();

      // Single byte and issue latency
      auto_mode = 1'b1;
      push_wr(8'hA5, 1'b1);
      chk("single_count1", 32'(count), 1);
      chk("single_no_send_yet", 32'(tx_send), 0);
      step();
      chk("single_send", 32'(tx_send), 1);
      chk("single_data", 32'(tx_data), 32'hA5);
      step();
      chk("single_send_drop", 32'(tx_send), 0);
      repeat (3) step();
      chk("single_inflight_count", 32'(count), 1);
      chk("single_inflight_data", 32'(tx_data), 32'hA5);
      drain("single");
      chk("single_count0", 32'(count), 0);

      // Fill / overflow table with the transmitter held busy
      man_ready = 1'b0;
      auto_mode = 1'b0;
      for (int i = 0; i < 20; i++) begin
         wr_en   = vecs[i].wr;
         wr_data = vecs[i].data;
         clr_ovf = vecs[i].clr;
         if (vecs[i].accept) exp_q.push_back(vecs[i].data);
         step();
         wr_en   = 1'b0;
         clr_ovf = 1'b0;
         chk($sformatf("vec%0d_count", i), 32'(count), 32'(vecs[i].cnt));
         chk($sformatf("vec%0d_full", i), 32'(full), 32'(vecs[i].full));
         chk($sformatf("vec%0d_empty", i), 32'(empty), 32'(vecs[i].empty));
         chk($sformatf("vec%0d_ovf", i), 32'(overflow), 32'(vecs[i].ovf));
         chk($sformatf("vec%0d_nosend", i), 32'(tx_send), 0);
      end

      // Full FIFO: write on the same clock as the pop
      man_ready = 1'b1;
      step();
      chk("fullpop_send", 32'(tx_send), 1);
      chk("fullpop_first", 32'(tx_data), 32'h01);
      man_ready = 1'b0;
      repeat (3) step();
      chk("fullpop_hold_count", 32'(count), 16);
      man_ready = 1'b1;
      push_wr(8'h77, 1'b1);
      chk("fullpop_count", 32'(count), 16);
      chk("fullpop_full", 32'(full), 1);
      chk("fullpop_ovf", 32'(overflow), 0);
      auto_mode = 1'b1;
      drain("fullpop");

      // Second 16-byte burst across the pointer wrap
      man_ready = 1'b0;
      auto_mode = 1'b0;
      for (int i = 0; i < 16; i++) push_wr(8'($urandom), 1'b1);
      chk("wrap_full", 32'(full), 1);
      chk("wrap_count", 32'(count), 16);
      auto_mode = 1'b1;
      drain("wrap");

      // Flush during WAIT_DONE; a same-cycle write is ignored
      man_ready = 1'b0;
      auto_mode = 1'b0;
      push_wr(8'hB1, 1'b1);
      push_wr(8'hB2, 1'b1);
      push_wr(8'hB3, 1'b1);
      man_ready = 1'b1;
      step();
      chk("flush_send", 32'(tx_send), 1);
      chk("flush_data", 32'(tx_data), 32'hB1);
      man_ready = 1'b0;
      repeat (3) step();
      flush   = 1'b1;
      wr_en   = 1'b1;
      wr_data = 8'hEE;
      step();
      flush = 1'b0;
      wr_en = 1'b0;
      chk("flush_count", 32'(count), 0);
      chk("flush_empty", 32'(empty), 1);
      exp_q.delete();
      man_ready = 1'b1;
      for (int i = 0; i < 6; i++) begin
         step();
         chk($sformatf("flush_after%0d_count", i), 32'(count), 0);
         chk($sformatf("flush_after%0d_send", i), 32'(tx_send), 0);
      end
      auto_mode = 1'b1;
      push_wr(8'hC4, 1'b1);
      drain("postflush");

      // tx_data stability while writes arrive mid-frame
      push_wr(8'h3C, 1'b1);
      wait_send("stable");
      step();
      for (int i = 0; i < 8; i++) begin
         push_wr(8'($urandom), 1'b1);
         chk($sformatf("stable%0d_data", i), 32'(tx_data), 32'h3C);
      end
      drain("stable");

      // Asynchronous reset mid-traffic with overflow set
      man_ready = 1'b0;
      auto_mode = 1'b0;
      for (int i = 0; i < 17; i++) push_wr(8'(8'h40 + i), (i < 16));
      chk("midrst_ovf_set", 32'(overflow), 1);
      auto_mode = 1'b1;
      wait_send("midrst");
      repeat (3) step();
      #3;
      rst = 1'b0;
      #1;
      chk("midrst_empty", 32'(empty), 1);
      chk("midrst_full", 32'(full), 0);
      chk("midrst_count", 32'(count), 0);
      chk("midrst_send", 32'(tx_send), 0);
      chk("midrst_ovf", 32'(overflow), 0);
      chk("midrst_txdata", 32'(tx_data), 0);
      exp_q.delete();
      step();
      rst = 1'b1;
      repeat (20) step();
      chk("midrst_idle_count", 32'(count), 0);
      chk("midrst_idle_empty", 32'(empty), 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
